// File: rtl/stat_px_rle_enc.sv
// -----------------------------------------------------------------------------
// stat_px_rle_enc
//
// Encodes a stream of monochrome pixels into 16-bit static-pixel RLE words.
// It takes one pixel per cycle in and emits packed words out, with a
// valid/ready handshake on each side.
//
// Word format:
//   bit 15     : word type, 0 = raw, 1 = length-encoded
//   raw        : bits 14..0 hold pixels, first collected pixel in bit 0,
//                unused high bits are 0
//   length     : bit 14 is the pixel value, bits 13..0 hold run length - 1
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   px_valid/ready handshake for the input pixel px_in
//   px_last        the accepted pixel is the final pixel of the frame
//   word_valid     word_data/word_last hold an encoded word
//   word_data      encoded word
//   word_last      the word is the final word of the frame
//   word_ready     the sink accepts the word
// -----------------------------------------------------------------------------
module stat_px_rle_enc #(
    parameter int RUN_MAX  = 16384,  // longest run in one word, RUN_MAX-1 fits 14 bits
    parameter int RAW_BITS = 15      // pixels per raw word, fixed by the format
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        px_valid,
    input  logic        px_in,
    input  logic        px_last,
    output logic        px_ready,
    output logic        word_valid,
    output logic [15:0] word_data,
    output logic        word_last,
    input  logic        word_ready
);

    typedef enum logic [1:0] {COLLECT, RUN, TAIL} state_t;

    state_t              state, state_nxt;
    logic [RAW_BITS-1:0] col_buf, buf_nxt, buf_ins;
    logic [3:0]          n, n_nxt, n_inc;
    logic                uni, uni_nxt, uni_ins;
    logic [14:0]         run, run_nxt, run_inc;
    logic [13:0]         run_dec;
    logic                rv, rv_nxt;
    logic                tail_px, tail_nxt;
    logic                out_free, accept;
    logic                emit, emit_last;
    logic [15:0]         emit_data;

    // The single output register can take a new word when it is empty or
    // when its current word is consumed on this same edge.
    assign out_free = !word_valid || word_ready;
    assign px_ready = (state != TAIL) && out_free;
    assign accept   = px_valid && px_ready;
    assign n_inc    = n + 4'd1;
    assign run_inc  = run + 15'd1;
    // Only used when a run breaks, and a run in progress never exceeds
    // RUN_MAX-1, so the low 14 bits are sufficient.
    assign run_dec  = run[13:0] - 14'd1;

    // Collect buffer with the incoming pixel placed at slot n. A fresh word
    // (n == 0) starts from zeros so unused high bits of a raw word stay 0.
    always_comb begin
        buf_ins = (n == 4'd0) ? '0 : col_buf;
        for (int i = 0; i < RAW_BITS; i++) begin
            if (4'(i) == n) buf_ins[i] = px_in;
        end
        uni_ins = (n == 4'd0) || (uni && (px_in == col_buf[0]));
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_nxt = state;
        buf_nxt   = col_buf;
        n_nxt     = n;
        uni_nxt   = uni;
        run_nxt   = run;
        rv_nxt    = rv;
        tail_nxt  = tail_px;
        emit      = 1'b0;
        emit_last = 1'b0;
        emit_data = '0;

        case (state)
            COLLECT: begin
                if (accept) begin
                    buf_nxt = buf_ins;
                    n_nxt   = n_inc;
                    uni_nxt = uni_ins;
                    if (px_last) begin
                        // Frame end: short uniform groups become a length
                        // word (length - 1 equals the old n), others raw.
                        emit      = 1'b1;
                        emit_last = 1'b1;
                        n_nxt     = 4'd0;
                        emit_data = uni_ins ? {1'b1, buf_ins[0], 10'd0, n}
                                            : {1'b0, buf_ins};
                    end else if (n_inc == 4'(RAW_BITS)) begin
                        n_nxt = 4'd0;
                        if (uni_ins) begin
                            // A full uniform group turns into a run; nothing
                            // is emitted until the run ends.
                            state_nxt = RUN;
                            run_nxt   = 15'(RAW_BITS);
                            rv_nxt    = px_in;
                        end else begin
                            emit      = 1'b1;
                            emit_data = {1'b0, buf_ins};
                        end
                    end
                end
            end

            RUN: begin
                if (accept) begin
                    if (px_in == rv) begin
                        if (px_last) begin
                            // Old run already equals new length - 1.
                            emit      = 1'b1;
                            emit_last = 1'b1;
                            emit_data = {1'b1, rv, run[13:0]};
                            state_nxt = COLLECT;
                            run_nxt   = '0;
                        end else if (run_inc == 15'(RUN_MAX)) begin
                            emit      = 1'b1;
                            emit_data = {1'b1, rv, 14'(RUN_MAX - 1)};
                            state_nxt = COLLECT;
                            run_nxt   = '0;
                        end else begin
                            run_nxt = run_inc;
                        end
                    end else begin
                        emit      = 1'b1;
                        emit_data = {1'b1, rv, run_dec};
                        run_nxt   = '0;
                        if (px_last) begin
                            // The breaking pixel also ends the frame; it needs
                            // its own word once the register frees up.
                            state_nxt = TAIL;
                            tail_nxt  = px_in;
                        end else begin
                            state_nxt = COLLECT;
                            buf_nxt   = {{(RAW_BITS-1){1'b0}}, px_in};
                            n_nxt     = 4'd1;
                            uni_nxt   = 1'b1;
                        end
                    end
                end
            end

            TAIL: begin
                if (out_free) begin
                    emit      = 1'b1;
                    emit_last = 1'b1;
                    emit_data = {1'b1, tail_px, 14'd0};
                    state_nxt = COLLECT;
                end
            end

            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= COLLECT;
            col_buf    <= '0;
            n          <= 4'd0;
            uni        <= 1'b1;
            run        <= '0;
            rv         <= 1'b0;
            tail_px    <= 1'b0;
            word_valid <= 1'b0;
            word_data  <= '0;
            word_last  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state   <= state_nxt;
            col_buf <= buf_nxt;
            n       <= n_nxt;
            uni     <= uni_nxt;
            run     <= run_nxt;
            rv      <= rv_nxt;
            tail_px <= tail_nxt;
            // Data and last only change on a load, so they hold steady while
            // the sink stalls.
            if (emit) begin
                word_valid <= 1'b1;
                word_data  <= emit_data;
                word_last  <= emit_last;
            end else if (word_ready) begin
                word_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stat_px_rle_enc.sv
// -----------------------------------------------------------------------------
// tb_stat_px_rle_enc
//
// Self-checking bench for stat_px_rle_enc. A monitor collects every word
// handed over to the sink and checks stall behaviour; directed scenarios use
// literal expected words, random scenarios use a chunk-based reference model
// of the word format.
// -----------------------------------------------------------------------------
module tb_stat_px_rle_enc;

    localparam int RUN_MAX = 16384;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        px_valid = 1'b0;
    logic        px_in = 1'b0;
    logic        px_last = 1'b0;
    logic        word_ready = 1'b1;
    logic        px_ready;
    logic        word_valid;
    logic [15:0] word_data;
    logic        word_last;

    int compared   = 0;
    int mismatched = 0;

    // Words are kept as {last, data}.
    logic [16:0] exp_q[$];
    logic [16:0] got_q[$];

    bit          ready_rand = 1'b0;
    int          gap_pct    = 0;
    int          pxr_low    = 0;
    bit          hold_pend  = 1'b0;
    logic [16:0] hold_word  = '0;

    always #5 clk = ~clk;

    stat_px_rle_enc #(.RUN_MAX(RUN_MAX), .RAW_BITS(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .px_valid   (px_valid),
        .px_in      (px_in),
        .px_last    (px_last),
        .px_ready   (px_ready),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_last  (word_last),
        .word_ready (word_ready)
    );

    // Monitor: samples on the falling edge, drives word_ready after the rise.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_pend = 1'b0;
            end else begin
                if (hold_pend) begin
                    compared++;
                    if (!word_valid || {word_last, word_data} !== hold_word) begin
                        mismatched++;
                        $display("FAIL hold_stable: got valid=%0b word=%h, required valid=1 word=%h",
                                 word_valid, {word_last, word_data}, hold_word);
                    end
                end
                hold_pend = word_valid && !word_ready;
                hold_word = {word_last, word_data};
                if (word_valid && !word_ready) begin
                    compared++;
                    if (px_ready !== 1'b0) begin
                        mismatched++;
                        $display("FAIL px_ready_stall: got %b, required 0", px_ready);
                    end
                end
                if (word_valid && word_ready) got_q.push_back({word_last, word_data});
                if (px_ready !== 1'b1) pxr_low++;
            end
            @(posedge clk);
            #1;
            word_ready = ready_rand ? ($urandom_range(0, 99) < 55) : 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: walks the frame in 15-pixel chunks and extends uniform
    // full chunks into runs, emitting words from the format rules directly.
    function automatic void model_frame(input bit px[$]);
        int len = px.size();
        int pos = 0;
        while (pos < len) begin
            int          take = (len - pos < 15) ? len - pos : 15;
            bit          u    = 1'b1;
            logic [14:0] raw  = '0;
            for (int k = 0; k < take; k++) begin
                raw[k] = px[pos + k];
                if (px[pos + k] != px[pos]) u = 1'b0;
            end
            if (pos + take == len) begin
                if (u) exp_q.push_back({1'b1, 1'b1, px[pos], 14'(take - 1)});
                else   exp_q.push_back({1'b1, 1'b0, raw});
                pos = len;
            end else if (!u) begin
                exp_q.push_back({1'b0, 1'b0, raw});
                pos += 15;
            end else begin
                int r = 15;
                bit l;
                while (pos + r < len && r < RUN_MAX && px[pos + r] == px[pos]) r++;
                l = (pos + r == len);
                if (r == RUN_MAX || l) begin
                    exp_q.push_back({l, 1'b1, px[pos], 14'(r - 1)});
                    pos += r;
                end else begin
                    exp_q.push_back({1'b0, 1'b1, px[pos], 14'(r - 1)});
                    pos += r;
                    if (pos == len - 1) begin
                        exp_q.push_back({1'b1, 1'b1, px[pos], 14'd0});
                        pos = len;
                    end
                end
            end
        end
    endfunction

    task automatic drive_frame(input bit px[$], input bit close);
        for (int i = 0; i < px.size(); i++) begin
            int waited = 0;
            while (gap_pct != 0 && $urandom_range(0, 99) < gap_pct) begin
                px_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            px_valid = 1'b1;
            px_in    = px[i];
            px_last  = close && (i == px.size() - 1);
            forever begin
                @(negedge clk);
                if (px_ready) break;
                waited++;
                if (waited > 2000) begin
                    compared++;
                    mismatched++;
                    $display("FAIL accept_timeout: pixel %0d not accepted within 2000 cycles", i);
                    px_valid = 1'b0;
                    px_last  = 1'b0;
                    return;
                end
            end
            @(posedge clk);
            #1;
        end
        px_valid = 1'b0;
        px_last  = 1'b0;
    endtask

    task automatic check_words(input string name);
        int waited = 0;
        while (got_q.size() < exp_q.size() && waited < 3000) begin
            @(posedge clk);
            #1;
            waited++;
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        compared++;
        if (got_q.size() != exp_q.size()) begin
            mismatched++;
            $display("FAIL %s word_count: got %0d, required %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            compared++;
            if (got_q[i] !== exp_q[i]) begin
                mismatched++;
                $display("FAIL %s word[%0d]: got last=%0b data=%h, required last=%0b data=%h",
                         name, i, got_q[i][16], got_q[i][15:0], exp_q[i][16], exp_q[i][15:0]);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic const_frame(output bit px[$], input bit v, input int len);
        px.delete();
        for (int i = 0; i < len; i++) px.push_back(v);
    endtask

    task automatic random_frame(output bit px[$], input int len);
        bit v = 1'(($urandom_range(0, 1)));
        px.delete();
        while (px.size() < len) begin
            int seg = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 60))
                                                  : int'($urandom_range(1, 4));
            for (int k = 0; k < seg && px.size() < len; k++) px.push_back(v);
            if ($urandom_range(0, 9) < 7) v = ~v;
        end
    endtask

    task automatic test_reset();
        #12;
        compared += 3;
        if (word_valid !== 1'b0) begin mismatched++; $display("FAIL reset_word_valid: got %b, required 0", word_valid); end
        if (word_data !== 16'h0) begin mismatched++; $display("FAIL reset_word_data: got %h, required 0000", word_data); end
        if (word_last !== 1'b0) begin mismatched++; $display("FAIL reset_word_last: got %b, required 0", word_last); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        compared += 2;
        if (px_ready !== 1'b1) begin mismatched++; $display("FAIL reset_px_ready: got %b, required 1", px_ready); end
        if (word_valid !== 1'b0) begin mismatched++; $display("FAIL reset_idle_valid: got %b, required 0", word_valid); end
    endtask

    task automatic test_raw_alternating();
        bit px[$];
        for (int i = 0; i < 15; i++) px.push_back(1'(i % 2));
        exp_q.push_back({1'b1, 16'h2AAA});
        drive_frame(px, 1'b1);
        check_words("raw_alternating");
    endtask

    task automatic test_short_frames();
        bit px[$];
        px = '{1'b1, 1'b0, 1'b1};
        exp_q.push_back({1'b1, 16'h0005});
        drive_frame(px, 1'b1);
        px = '{1'b1, 1'b1};
        exp_q.push_back({1'b1, 16'hC001});
        drive_frame(px, 1'b1);
        px = '{1'b0};
        exp_q.push_back({1'b1, 16'h8000});
        drive_frame(px, 1'b1);
        check_words("short_frames");
    endtask

    task automatic test_run_20();
        bit px[$];
        ready_rand = 1'b0;
        pxr_low = 0;
        const_frame(px, 1'b1, 20);
        exp_q.push_back({1'b1, 16'hC013});
        drive_frame(px, 1'b1);
        check_words("run_20");
        compared++;
        if (pxr_low !== 0) begin mismatched++; $display("FAIL run_20_px_ready_low: got %0d cycles, required 0", pxr_low); end
    endtask

    task automatic test_back_to_back_backpressure();
        bit px[$];
        ready_rand = 1'b1;
        gap_pct = 20;
        const_frame(px, 1'b1, 20);
        for (int f = 0; f < 3; f++) begin
            exp_q.push_back({1'b1, 16'hC013});
            drive_frame(px, 1'b1);
        end
        check_words("run_20_backpressure");
        ready_rand = 1'b0;
        gap_pct = 0;
    endtask

    task automatic test_tail();
        bit px[$];
        pxr_low = 0;
        const_frame(px, 1'b1, 31);
        px.push_back(1'b0);
        exp_q.push_back({1'b0, 16'hC01E});
        exp_q.push_back({1'b1, 16'h8000});
        drive_frame(px, 1'b1);
        check_words("tail");
        compared++;
        if (pxr_low !== 1) begin mismatched++; $display("FAIL tail_px_ready_low: got %0d cycles, required 1", pxr_low); end
    endtask

    task automatic test_run_max();
        bit px[$];
        const_frame(px, 1'b0, RUN_MAX + 1);
        exp_q.push_back({1'b0, 16'hBFFF});
        exp_q.push_back({1'b1, 16'h8000});
        drive_frame(px, 1'b1);
        check_words("run_max_plus_one");
        const_frame(px, 1'b1, RUN_MAX);
        exp_q.push_back({1'b1, 16'hFFFF});
        drive_frame(px, 1'b1);
        check_words("run_max_exact");
    endtask

    task automatic test_reset_mid_run();
        bit px[$];
        const_frame(px, 1'b1, 25);
        drive_frame(px, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        compared++;
        if (word_valid !== 1'b0) begin mismatched++; $display("FAIL mid_reset_valid: got %b, required 0", word_valid); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        compared++;
        if (got_q.size() != 0) begin mismatched++; $display("FAIL mid_reset_words: got %0d, required 0", got_q.size()); end
        got_q.delete();
        random_frame(px, 40);
        model_frame(px);
        drive_frame(px, 1'b1);
        check_words("after_reset");
    endtask

    task automatic test_random();
        bit px[$];
        ready_rand = 1'b1;
        gap_pct = 30;
        for (int f = 0; f < 10; f++) begin
            random_frame(px, int'($urandom_range(1, 150)));
            model_frame(px);
            drive_frame(px, 1'b1);
        end
        check_words("random_frames");
        ready_rand = 1'b0;
        gap_pct = 0;
    endtask

    initial begin
        test_reset();
        test_raw_alternating();
        test_short_frames();
        test_run_20();
        test_back_to_back_backpressure();
        test_tail();
        test_run_max();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
